// File: rtl/pe_acc_pkg.sv
// Shared widths, pipeline control record and saturating/rounding arithmetic
// helpers for the pe_acc processing element.
package pe_acc_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 32;

  // All wide arithmetic is done in 64 bits, so ACC_WIDTH must stay below 63.
  typedef logic signed [63:0] wide_t;
  localparam wide_t WIDE_ONE = 64'sd1;

  typedef struct packed {
    logic       valid;
    logic       first;
    logic       last;
    logic [4:0] shift;
    logic       relu;
  } beat_ctrl_t;

  function automatic int unsigned gpw_calc(int unsigned dw, int unsigned nmac4,
                                           int unsigned ngroups);
    return 2 * dw + 2 + $clog2(nmac4 / ngroups);
  endfunction

  function automatic int unsigned tot_calc(int unsigned dw, int unsigned nmac4);
    return 2 * dw + 2 + $clog2(nmac4);
  endfunction

  function automatic wide_t sat_max(int unsigned w);
    return (WIDE_ONE <<< (w - 1)) - WIDE_ONE;
  endfunction

  function automatic wide_t sat_min(int unsigned w);
    return -(WIDE_ONE <<< (w - 1));
  endfunction

  function automatic logic sat_hit(wide_t x, int unsigned w);
    return (x > sat_max(w)) || (x < sat_min(w));
  endfunction

  function automatic wide_t saturate(wide_t x, int unsigned w);
    if (x > sat_max(w)) return sat_max(w);
    if (x < sat_min(w)) return sat_min(w);
    return x;
  endfunction

  // Round half up, then arithmetic shift right.
  function automatic wide_t round_shift(wide_t x, logic [4:0] sh);
    wide_t rnd;
    rnd = (sh == 5'd0) ? '0 : (WIDE_ONE <<< (sh - 5'd1));
    return (x + rnd) >>> sh;
  endfunction

endpackage

// File: rtl/pe_acc_dot4.sv
// Registered 4-lane signed multiply-add: sum = a0*b0 + a1*b1 + a2*b2 + a3*b3.
module dot4_s
  import pe_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*DATA_WIDTH-1:0]       a,
  input  logic [4*DATA_WIDTH-1:0]       b,
  output logic signed [2*DATA_WIDTH+1:0] sum
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 2;

  logic signed [DATA_WIDTH-1:0]   av;
  logic signed [DATA_WIDTH-1:0]   bv;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [PW-1:0]           sum_c;

  always_comb begin
    av    = '0;
    bv    = '0;
    prod  = '0;
    sum_c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      av    = a[k*DATA_WIDTH +: DATA_WIDTH];
      bv    = b[k*DATA_WIDTH +: DATA_WIDTH];
      prod  = av * bv;
      sum_c = sum_c + PW'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  sum <= '0;
    else if (en) sum <= sum_c;
  end

endmodule

// File: rtl/pe_acc.sv
// Multi-beat signed dot-product processing element: dot units, group reduction,
// packet accumulation with bias, then rounding/ReLU/saturating quantisation.
module pe_acc
  import pe_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_MAC4   = 16,
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH  = 8,
  localparam int unsigned GPW = gpw_calc(DATA_WIDTH, NUM_MAC4, NUM_GROUPS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_first,
  input  logic                                  in_last,
  input  logic [NUM_MAC4*4*DATA_WIDTH-1:0]      in_data,
  input  logic [NUM_MAC4*4*DATA_WIDTH-1:0]      in_weights,
  input  logic [DATA_WIDTH-1:0]                 in_bias,
  input  logic [4:0]                            cfg_shift,
  input  logic                                  cfg_relu,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [ACC_WIDTH-1:0]           out_acc,
  output logic signed [OUT_WIDTH-1:0]           out_q,
  output logic signed [NUM_GROUPS*GPW-1:0]      out_psum,
  output logic                                  out_sat
);

  localparam int unsigned PW  = 2 * DATA_WIDTH + 2;
  localparam int unsigned UPG = NUM_MAC4 / NUM_GROUPS;
  localparam int unsigned TW  = tot_calc(DATA_WIDTH, NUM_MAC4);

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  // S1: dot units plus beat control
  logic signed [PW-1:0]         dot [NUM_MAC4];
  beat_ctrl_t                   s1_ctrl;
  logic signed [DATA_WIDTH-1:0] s1_bias;

  for (genvar u = 0; u < NUM_MAC4; u++) begin : g_dot
    dot4_s #(.DATA_WIDTH(DATA_WIDTH)) u_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .a     (in_data[u*4*DATA_WIDTH +: 4*DATA_WIDTH]),
      .b     (in_weights[u*4*DATA_WIDTH +: 4*DATA_WIDTH]),
      .sum   (dot[u])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctrl <= '0;
      s1_bias <= '0;
    end else if (adv) begin
      s1_ctrl.valid <= in_valid;
      s1_ctrl.first <= in_first;
      s1_ctrl.last  <= in_last;
      s1_ctrl.shift <= cfg_shift;
      s1_ctrl.relu  <= cfg_relu;
      s1_bias       <= in_bias;
    end
  end

  // S2: group sums and beat total
  logic signed [GPW-1:0]        grp_c  [NUM_GROUPS];
  logic signed [TW-1:0]         tot_c;
  logic signed [GPW-1:0]        s2_grp [NUM_GROUPS];
  logic signed [TW-1:0]         s2_tot;
  beat_ctrl_t                   s2_ctrl;
  logic signed [DATA_WIDTH-1:0] s2_bias;

  always_comb begin
    tot_c = '0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      grp_c[g] = '0;
      for (int unsigned u = 0; u < UPG; u++)
        grp_c[g] = grp_c[g] + GPW'(dot[g*UPG+u]);
      tot_c = tot_c + TW'(grp_c[g]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) s2_grp[g] <= '0;
      s2_tot  <= '0;
      s2_ctrl <= '0;
      s2_bias <= '0;
    end else if (adv) begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) s2_grp[g] <= grp_c[g];
      s2_tot  <= tot_c;
      s2_ctrl <= s2_ctrl.valid ? s1_ctrl : s1_ctrl;
      s2_bias <= s1_bias;
    end
  end

  // S3: packet accumulation with sticky saturation flag
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        sat_q;
  wide_t                       base_w;
  wide_t                       sum_w;
  logic                        acc_ovf;
  logic signed [ACC_WIDTH-1:0] acc_new;
  logic                        sat_now;

  always_comb begin
    base_w  = s2_ctrl.first ? wide_t'(s2_bias) : wide_t'(acc_q);
    sum_w   = base_w + wide_t'(s2_tot);
    acc_ovf = sat_hit(sum_w, ACC_WIDTH);
    acc_new = ACC_WIDTH'(saturate(sum_w, ACC_WIDTH));
    sat_now = acc_ovf || (sat_q && !s2_ctrl.first);
  end

  logic                        s3_valid;
  logic                        s3_last;
  logic [4:0]                  s3_shift;
  logic                        s3_relu;
  logic signed [ACC_WIDTH-1:0] s3_acc;
  logic                        s3_sat;
  logic signed [GPW-1:0]       s3_grp [NUM_GROUPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_shift <= '0;
      s3_relu  <= 1'b0;
      s3_acc   <= '0;
      s3_sat   <= 1'b0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) s3_grp[g] <= '0;
    end else if (adv) begin
      s3_valid <= s2_ctrl.valid;
      s3_last  <= s2_ctrl.last;
      s3_shift <= s2_ctrl.shift;
      s3_relu  <= s2_ctrl.relu;
      if (s2_ctrl.valid) begin
        s3_acc <= acc_new;
        s3_sat <= sat_now;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) s3_grp[g] <= s2_grp[g];
        // A closing beat hands its sum to the output stage and leaves the accumulator empty.
        if (s2_ctrl.last) begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end else begin
          acc_q <= acc_new;
          sat_q <= sat_now;
        end
      end
    end
  end

  // Output stage: quantise the closed packet and hold it until consumed
  wide_t                       q_w;
  logic                        q_clip;
  logic signed [OUT_WIDTH-1:0] q_c;

  always_comb begin
    q_w = round_shift(wide_t'(s3_acc), s3_shift);
    if (s3_relu && (q_w < 0)) q_w = '0;
    q_clip = sat_hit(q_w, OUT_WIDTH);
    q_c    = OUT_WIDTH'(saturate(q_w, OUT_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_q     <= '0;
      out_psum  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_valid && s3_last;
      if (s3_valid && s3_last) begin
        out_acc <= s3_acc;
        out_q   <= q_c;
        out_sat <= s3_sat || q_clip;
        for (int unsigned g = 0; g < NUM_GROUPS; g++)
          out_psum[g*GPW +: GPW] <= s3_grp[g];
      end
    end
  end

endmodule

// File: tb/tb_pe_acc.sv
// Self-checking bench for pe_acc: a reference model pushes expected packet
// results to a scoreboard that a negedge monitor pops on each output handshake.
module tb_pe_acc;

  localparam int unsigned DW    = 8;
  localparam int unsigned NM    = 16;
  localparam int unsigned NG    = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned OW    = 8;
  localparam int unsigned LANES = NM * 4;
  localparam int unsigned LPG   = LANES / NG;
  localparam int unsigned GPW   = 2 * DW + 2 + $clog2(NM / NG);

  typedef struct {
    logic signed [AW-1:0]    acc;
    logic signed [OW-1:0]    q;
    logic [NG*GPW-1:0]       psum;
    logic                    sat;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic                     in_first = 1'b0;
  logic                     in_last = 1'b0;
  logic [LANES*DW-1:0]      in_data = '0;
  logic [LANES*DW-1:0]      in_weights = '0;
  logic [DW-1:0]            in_bias = '0;
  logic [4:0]               cfg_shift = '0;
  logic                     cfg_relu = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [AW-1:0]     out_acc;
  logic signed [OW-1:0]     out_q;
  logic signed [NG*GPW-1:0] out_psum;
  logic                     out_sat;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  longint m_acc = 0;
  logic   m_sat = 1'b0;

  pe_acc #(
    .DATA_WIDTH (DW),
    .NUM_MAC4   (NM),
    .NUM_GROUPS (NG),
    .ACC_WIDTH  (AW),
    .OUT_WIDTH  (OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_first   (in_first),
    .in_last    (in_last),
    .in_data    (in_data),
    .in_weights (in_weights),
    .in_bias    (in_bias),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_q      (out_q),
    .out_psum   (out_psum),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [LANES*DW-1:0] rand_vec();
    logic [LANES*DW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Reference behaviour of one accepted beat, straight from the packet rules.
  task automatic model_beat(input logic first, input logic last,
                            input logic [DW-1:0] bias,
                            input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w,
                            input logic [4:0] sh, input logic relu);
    longint grp[NG];
    longint s, r;
    longint amax, amin;
    logic   sat, qc;
    exp_t   e;
    amax = (longint'(1) <<< (AW - 1)) - 1;
    amin = -(longint'(1) <<< (AW - 1));
    for (int g = 0; g < NG; g++) grp[g] = 0;
    for (int j = 0; j < LANES; j++)
      grp[j / LPG] += longint'($signed(d[j*DW +: DW])) * longint'($signed(w[j*DW +: DW]));
    s = first ? longint'($signed(bias)) : m_acc;
    for (int g = 0; g < NG; g++) s += grp[g];
    sat = (s > amax) || (s < amin) || (m_sat && !first);
    if (s > amax) s = amax;
    if (s < amin) s = amin;
    if (last) begin
      r = (sh == 0) ? s : ((s + (longint'(1) <<< (sh - 1))) >>> sh);
      if (relu && r < 0) r = 0;
      qc = (r > 127) || (r < -128);
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      e.acc = AW'(s);
      e.q   = OW'(r);
      for (int g = 0; g < NG; g++) e.psum[g*GPW +: GPW] = GPW'(grp[g]);
      e.sat = sat || qc;
      sb.push_back(e);
      m_acc = 0;
      m_sat = 1'b0;
    end else begin
      m_acc = s;
      m_sat = sat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic first, input logic last, input logic [DW-1:0] bias,
                      input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w);
    int n;
    in_valid   = 1'b1;
    in_first   = first;
    in_last    = last;
    in_bias    = bias;
    in_data    = d;
    in_weights = w;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_accept got=in_ready_low exp=accepted");
    end
    @(posedge clk);
    model_beat(first, last, bias, d, w, cfg_shift, cfg_relu);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got=%0d_pending exp=0_pending", name, sb.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=acc_%0d exp=no_result", out_acc);
      end else begin
        mon_e = sb.pop_front();
        if (out_acc !== mon_e.acc) begin
          bad++;
          $display("FAIL sb_acc got=%0d exp=%0d", out_acc, mon_e.acc);
        end
        total++;
        if (out_q !== mon_e.q) begin
          bad++;
          $display("FAIL sb_q got=%0d exp=%0d", out_q, mon_e.q);
        end
        total++;
        if (out_psum !== mon_e.psum) begin
          bad++;
          $display("FAIL sb_psum got=%h exp=%h", out_psum, mon_e.psum);
        end
        total++;
        if (out_sat !== mon_e.sat) begin
          bad++;
          $display("FAIL sb_sat got=%0b exp=%0b", out_sat, mon_e.sat);
        end
      end
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({out_valid, out_sat} !== 2'b00 || out_acc !== '0 || out_q !== '0 || out_psum !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=v%0b_acc%0d_q%0d exp=all_zero", out_valid, out_acc, out_q);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_single();
    int n;
    out_ready = 1'b1;
    cfg_shift = 5'd2;
    cfg_relu  = 1'b0;
    send(1'b1, 1'b1, 8'd3, fill(8'd1), fill(8'd1));
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=3", n);
    end
    total++;
    if (out_acc !== 32'sd67 || out_q !== 8'sd17) begin
      bad++;
      $display("FAIL single_values got=acc%0d_q%0d exp=acc67_q17", out_acc, out_q);
    end
    wait_drain("single");
  endtask

  task automatic test_multi_relu();
    int n;
    cfg_shift = 5'd4;
    cfg_relu  = 1'b1;
    send(1'b1, 1'b0, -8'sd5, fill(8'd2), fill(-8'sd3));
    send(1'b0, 1'b0, 8'd0,   fill(8'd2), fill(-8'sd3));
    send(1'b0, 1'b1, 8'd0,   fill(8'd2), fill(-8'sd3));
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    // 64 lanes x (2 * -3) x 3 beats, plus bias -5.
    total++;
    if (out_acc !== -32'sd1157 || out_q !== 8'sd0 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL multi_relu got=acc%0d_q%0d_sat%0b exp=acc-1157_q0_sat0", out_acc, out_q, out_sat);
    end
    wait_drain("multi_relu");
  endtask

  task automatic test_quant_sat();
    int n;
    cfg_shift = 5'd0;
    cfg_relu  = 1'b0;
    send(1'b1, 1'b1, 8'd0, fill(8'h80), fill(8'h80));
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (out_acc !== 32'sd1048576 || out_q !== 8'sd127 || out_sat !== 1'b1) begin
      bad++;
      $display("FAIL quant_sat got=acc%0d_q%0d_sat%0b exp=acc1048576_q127_sat1", out_acc, out_q, out_sat);
    end
    wait_drain("quant_sat");
  endtask

  task automatic test_acc_sat();
    cfg_shift = 5'd20;
    cfg_relu  = 1'b0;
    for (int i = 0; i < 2100; i++)
      send(i == 0, i == 2099, 8'd0, fill(8'h80), fill(8'h80));
    wait_drain("acc_sat");
  endtask

  task automatic test_stall();
    int n;
    cfg_shift = 5'd7;
    cfg_relu  = 1'b0;
    out_ready = 1'b0;
    send(1'b1, 1'b1, DW'($urandom), rand_vec(), rand_vec());
    send(1'b1, 1'b1, DW'($urandom), rand_vec(), rand_vec());
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_in_ready got=%0b exp=0", in_ready);
      end
      total++;
      if (out_valid !== 1'b1 || out_acc !== sb[0].acc || out_q !== sb[0].q) begin
        bad++;
        $display("FAIL stall_hold got=v%0b_acc%0d exp=v1_acc%0d", out_valid, out_acc, sb[0].acc);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_shift = 5'd3;
    for (int i = 0; i < 4; i++)
      send(1'b1, 1'b1, DW'($urandom), rand_vec(), rand_vec());
    n = 0;
    while (out_valid && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL b2b_continuous got=%0d exp=4", n);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid();
    cfg_shift = 5'd0;
    out_ready = 1'b0;
    send(1'b1, 1'b1, 8'd1, rand_vec(), rand_vec());
    send(1'b1, 1'b0, 8'd2, rand_vec(), rand_vec());
    send(1'b0, 1'b0, 8'd0, rand_vec(), rand_vec());
    tick();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pending got=%0b exp=1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_sat} !== 2'b00 || out_acc !== '0 || out_q !== '0 || out_psum !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got=v%0b_acc%0d_q%0d exp=all_zero", out_valid, out_acc, out_q);
    end
    sb.delete();
    m_acc = 0;
    m_sat = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(1'b1, 1'b1, 8'd7, rand_vec(), rand_vec());
    wait_drain("rstmid");
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_restart();
    cfg_shift = 5'd5;
    cfg_relu  = 1'b0;
    send(1'b1, 1'b0, DW'($urandom), rand_vec(), rand_vec());
    send(1'b1, 1'b0, DW'($urandom), rand_vec(), rand_vec());
    send(1'b0, 1'b1, DW'($urandom), rand_vec(), rand_vec());
    wait_drain("restart");
    send(1'b0, 1'b1, DW'($urandom), rand_vec(), rand_vec());
    wait_drain("orphan");
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_relu();
    test_quant_sat();
    test_acc_sat();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    for (int c = 0; c < 5; c++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
